alarm_tone_gen: RTL and testbench

ALARM_TONE_GEN -- requirements
Module: alarm_tone_gen

---
 rtl/alarm_tone_gen.sv | 155 +++++++++++++++
 tb/tb_alarm_tone_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm beeper: gated square-wave tone in a BEEP/GAP cadence with stop and auto-silence.
// Optional macro ALARM_TIMEOUT_EN enables the auto-silence timeout counter.
module alarm_tone_gen #(
  parameter int CLK_HZ    = 50000000,
  parameter int TONE_HZ   = 2000,
  parameter int BEEP_MS   = 250,
  parameter int GAP_MS    = 250,
  parameter int TIMEOUT_S = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic aud_en,
  input  logic stop,
  output logic aud_out,
  output logic beeping,
  output logic timed_out
);

  localparam int HALF     = CLK_HZ / (2 * TONE_HZ);
  localparam int BEEP_CYC = (CLK_HZ / 1000) * BEEP_MS;
  localparam int GAP_CYC  = (CLK_HZ / 1000) * GAP_MS;
  localparam int SEG_MAX  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int SEG_W    = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
  localparam int HALF_W   = (HALF > 1) ? $clog2(HALF) : 1;

  if (HALF < 1) begin : g_bad_half
    $fatal(1, "alarm_tone_gen: HALF must be >= 1");
  end
  if (BEEP_CYC < 1) begin : g_bad_beep
    $fatal(1, "alarm_tone_gen: BEEP_CYC must be >= 1");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $fatal(1, "alarm_tone_gen: GAP_CYC must be >= 1");
  end
  if (TIMEOUT_S < 0) begin : g_bad_to
    $fatal(1, "alarm_tone_gen: TIMEOUT_S must be >= 0");
  end

  typedef enum logic [1:0] {IDLE, BEEP, GAP, DONE} state_t;

  state_t            state, state_d;
  logic [SEG_W-1:0]  seg_cnt, seg_d;
  logic [HALF_W-1:0] tone_cnt, tone_d;
  logic              aud_d, beep_d, tflag_d;
  logic              to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seg_cnt   <= '0;
      tone_cnt  <= '0;
      aud_out   <= 1'b0;
      beeping   <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_d;
      seg_cnt   <= seg_d;
      tone_cnt  <= tone_d;
      aud_out   <= aud_d;
      beeping   <= beep_d;
      timed_out <= tflag_d;
    end
  end

  // Outputs are computed for the next state so they register in step with it.
  always_comb begin
    state_d = state;
    seg_d   = '0;
    tone_d  = '0;
    aud_d   = 1'b0;
    beep_d  = 1'b0;
    tflag_d = timed_out;
    if (!aud_en) begin
      state_d = IDLE;
      tflag_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stop) begin
            state_d = DONE;
            tflag_d = 1'b0;
          end else begin
            state_d = BEEP;
            aud_d   = 1'b1;
            beep_d  = 1'b1;
          end
        end
        BEEP: begin
          if (stop) begin
            state_d = DONE;
            tflag_d = 1'b0;
          end else if (to_hit) begin
            state_d = DONE;
            tflag_d = 1'b1;
          end else if (seg_cnt == SEG_W'(BEEP_CYC - 1)) begin
            state_d = GAP;
            beep_d  = 1'b1;
          end else begin
            seg_d  = seg_cnt + 1'b1;
            beep_d = 1'b1;
            if (tone_cnt == HALF_W'(HALF - 1)) begin
              aud_d = ~aud_out;
            end else begin
              tone_d = tone_cnt + 1'b1;
              aud_d  = aud_out;
            end
          end
        end
        GAP: begin
          if (stop) begin
            state_d = DONE;
            tflag_d = 1'b0;
          end else if (to_hit) begin
            state_d = DONE;
            tflag_d = 1'b1;
          end else if (seg_cnt == SEG_W'(GAP_CYC - 1)) begin
            state_d = BEEP;
            aud_d   = 1'b1;
            beep_d  = 1'b1;
          end else begin
            seg_d  = seg_cnt + 1'b1;
            beep_d = 1'b1;
          end
        end
        default: state_d = DONE;
      endcase
    end
  end

`ifdef ALARM_TIMEOUT_EN
  localparam longint TO_CYC = longint'(CLK_HZ) * longint'(TIMEOUT_S);
  localparam int     TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            in_pat, in_pat_d;

  assign in_pat   = (state == BEEP) || (state == GAP);
  assign in_pat_d = (state_d == BEEP) || (state_d == GAP);
  assign to_hit   = in_pat && (to_cnt == TO_W'(TO_CYC - 1));

  // Only counts while staying inside the pattern; any exit clears it.
  always_comb begin
    to_cnt_d = '0;
    if (in_pat && in_pat_d) to_cnt_d = to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed self-checking bench for alarm_tone_gen (HALF=5, BEEP=20, GAP=10, TO=1000 cycles).
module tb_alarm_tone_gen;

  logic clk = 1'b0;
  logic rst, aud_en, stop;
  logic aud_out, beeping, timed_out;
  int   n_chk = 0;
  int   n_err = 0;

  alarm_tone_gen #(
    .CLK_HZ(1000), .TONE_HZ(100), .BEEP_MS(20), .GAP_MS(10), .TIMEOUT_S(1)
  ) dut (
    .clk(clk), .rst(rst), .aud_en(aud_en), .stop(stop),
    .aud_out(aud_out), .beeping(beeping), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic a, input logic b, input logic t);
    chk({tag, ".aud"}, 32'(aud_out), 32'(a));
    chk({tag, ".beep"}, 32'(beeping), 32'(b));
    chk({tag, ".to"}, 32'(timed_out), 32'(t));
  endtask

  task automatic restart();
    rst = 1'b1; aud_en = 1'b0; stop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Called in cycle 0 with aud_en just raised; checks cycles 1..n.
  task automatic run_pattern(input int n, input string tag);
    int  p;
    logic ea;
    for (int c = 1; c <= n; c++) begin
      tick();
`ifdef ALARM_TIMEOUT_EN
      if (c > 1000) begin
        outs($sformatf("%s.c%0d", tag, c), 1'b0, 1'b0, 1'b1);
        continue;
      end
`endif
      p  = (c - 1) % 30;
      ea = (p < 20) && (((p / 5) % 2) == 0);
      outs($sformatf("%s.c%0d", tag, c), ea, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; aud_en = 1'b1; stop = 1'b0;
    tick(); tick();
    outs("reset", 1'b0, 1'b0, 1'b0);

    // Basic cadence, long run: timeout (if built in) or indefinite pattern
    restart();
    aud_en = 1'b1;
`ifdef ALARM_TIMEOUT_EN
    run_pattern(1200, "long");
    aud_en = 1'b0;
    tick();
    outs("long.release", 1'b0, 1'b0, 1'b0);
`else
    run_pattern(3000, "long");
`endif

    // stop pulse during BEEP
    restart();
    aud_en = 1'b1;
    run_pattern(8, "stop");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    outs("stop.c9", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      outs($sformatf("stop.hold%0d", i), 1'b0, 1'b0, 1'b0);
    end
    aud_en = 1'b0;
    tick();
    outs("stop.idle", 1'b0, 1'b0, 1'b0);
    aud_en = 1'b1;
    tick();
    outs("stop.rearm", 1'b1, 1'b1, 1'b0);

    // stop held while arming from IDLE goes straight to DONE
    restart();
    aud_en = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    outs("idlestop.c1", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      outs($sformatf("idlestop.hold%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // aud_en drop in GAP, reassert later; timeout restarts from zero
    restart();
    aud_en = 1'b1;
    run_pattern(25, "drop");
    aud_en = 1'b0;
    for (int c = 26; c <= 40; c++) begin
      tick();
      outs($sformatf("drop.c%0d", c), 1'b0, 1'b0, 1'b0);
    end
    aud_en = 1'b1;
`ifdef ALARM_TIMEOUT_EN
    run_pattern(1010, "rearm");
`else
    run_pattern(70, "rearm");
`endif

    // reset held cycles 10-12 mid-beep
    restart();
    aud_en = 1'b1;
    run_pattern(10, "rst");
    rst = 1'b1;
    tick();
    outs("rst.c11", 1'b0, 1'b0, 1'b0);
    tick();
    outs("rst.c12", 1'b0, 1'b0, 1'b0);
    tick();
    outs("rst.c13", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run_pattern(35, "rst.after");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
